// File: rtl/calc1_defs.sv
// Shared calc1 encodings: command codes, response codes and port-driver FSM states.
package calc1_defs;

  localparam logic [0:3] CmdNop = 4'd0;
  localparam logic [0:3] CmdAdd = 4'd1;
  localparam logic [0:3] CmdSub = 4'd2;
  localparam logic [0:3] CmdShl = 4'd5;
  localparam logic [0:3] CmdShr = 4'd6;

  localparam logic [0:1] RespNone = 2'd0;
  localparam logic [0:1] RespOk   = 2'd1;
  localparam logic [0:1] RespOvf  = 2'd2;
  localparam logic [0:1] RespInv  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSend1,
    StSend2,
    StWaitResp,
    StDone
  } state_e;

endpackage

// File: rtl/calc1_port_driver_if.sv
// Operation/result handshakes plus the calc1 request and response wires for one port.
interface calc1_port_driver_if;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_data1;
  logic [0:31] op_data2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic        err_stray;

  modport slave (
    input  op_valid, op_cmd, op_data1, op_data2, out_resp, out_data, rsp_ready,
    output op_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout,
           err_stray
  );

  modport master (
    output op_valid, op_cmd, op_data1, op_data2, out_resp, out_data, rsp_ready,
    input  op_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout,
           err_stray
  );
endinterface

// File: rtl/calc1_wait_timer.sv
// 8-bit response-wait counter; expired flags the cycle whose increment reaches TIMEOUT.
module calc1_wait_timer #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the incremented value lets the TIMEOUT-th empty sample complete the wait.
  assign expired = enable && (count_d == Limit);

endmodule

// File: rtl/calc1_port_driver.sv
// Request-side agent for one calc1 port: two-cycle request, bounded wait, registered result.
module calc1_port_driver
  import calc1_defs::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input logic                 c_clk,
  input logic                 reset,
  calc1_port_driver_if.slave  port
);

  state_e      state_q, state_d;
  logic [0:31] data2_q, data2_d;
  logic [0:3]  req_cmd_q, req_cmd_d;
  logic [0:31] req_data_q, req_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [0:1]  rsp_code_q, rsp_code_d;
  logic [0:31] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        err_stray_q, err_stray_d;
  logic        resp_seen;
  logic        timer_expired;

  assign resp_seen = (port.out_resp != RespNone);

  calc1_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .c_clk   (c_clk),
    .reset   (reset),
    .clear   (state_q == StSend2),
    .enable  ((state_q == StWaitResp) && !resp_seen),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    data2_d       = data2_q;
    req_cmd_d     = CmdNop;
    req_data_d    = '0;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    err_stray_d   = err_stray_q || (resp_seen && (state_q != StWaitResp));

    unique case (state_q)
      StIdle: begin
        if (port.op_valid) begin
          data2_d = port.op_data2;
          if (port.op_cmd == CmdNop) begin
            state_d       = StDone;
            rsp_code_d    = RespNone;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d    = StSend1;
            req_cmd_d  = port.op_cmd;
            req_data_d = port.op_data1;
          end
        end
      end
      StSend1: begin
        state_d    = StSend2;
        req_data_d = data2_q;
      end
      StSend2: begin
        state_d = StWaitResp;
      end
      StWaitResp: begin
        // A real response beats a same-cycle timeout.
        if (resp_seen) begin
          state_d       = StDone;
          rsp_code_d    = port.out_resp;
          rsp_data_d    = port.out_data;
          rsp_timeout_d = 1'b0;
        end else if (timer_expired) begin
          state_d       = StDone;
          rsp_code_d    = RespNone;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      StDone: begin
        if (port.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rsp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      data2_q       <= '0;
      req_cmd_q     <= CmdNop;
      req_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= RespNone;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      data2_q       <= data2_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_stray_q   <= err_stray_d;
    end
  end

  assign port.op_ready     = (state_q == StIdle) && !reset;
  assign port.req_cmd_out  = req_cmd_q;
  assign port.req_data_out = req_data_q;
  assign port.rsp_valid    = rsp_valid_q;
  assign port.rsp_code     = rsp_code_q;
  assign port.rsp_data     = rsp_data_q;
  assign port.rsp_timeout  = rsp_timeout_q;
  assign port.err_stray    = err_stray_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver with a result scoreboard and a scripted calculator model.
module tb_calc1_port_driver;
  import calc1_defs::*;

  localparam int unsigned Tmo = 10;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  calc1_port_driver_if bus ();

  calc1_port_driver #(
    .TIMEOUT (Tmo)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .port  (bus)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer an op (leaves op_valid high until accepted), then check the two request cycles.
  task automatic send_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
    int waited = 0;
    bus.op_valid = 1'b1;
    bus.op_cmd   = cmd;
    bus.op_data1 = d1;
    bus.op_data2 = d2;
    while (bus.op_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("op_ready_wait", 32'(bus.op_ready), 32'd1);
    tick();
    bus.op_valid = 1'b0;
    if (cmd != 4'd0) begin
      check("send1_cmd", 32'(bus.req_cmd_out), 32'(cmd));
      check("send1_data", bus.req_data_out, d1);
      tick();
      check("send2_cmd", 32'(bus.req_cmd_out), 32'd0);
      check("send2_data", bus.req_data_out, d2);
    end else begin
      check("nop_req_cmd", 32'(bus.req_cmd_out), 32'd0);
      check("nop_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
  endtask

  task automatic respond(input int delay, input logic [1:0] code, input logic [31:0] data);
    repeat (delay) tick();
    bus.out_resp = code;
    bus.out_data = data;
    tick();
    bus.out_resp = 2'd0;
    bus.out_data = '0;
  endtask

  // Wait (bounded) for a result, compare with the scoreboard, optionally stall rsp_ready.
  task automatic collect(input int hold);
    int   waited = 0;
    exp_t e;
    while (bus.rsp_valid !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("rsp_code", 32'(bus.rsp_code), 32'(e.code));
    check("rsp_data", bus.rsp_data, e.data);
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_code", 32'(bus.rsp_code), 32'(e.code));
      check("hold_data", bus.rsp_data, e.data);
      check("hold_op_ready", 32'(bus.op_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("post_rsp_op_ready", 32'(bus.op_ready), 32'd1);
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_cmd    = '0;
    bus.op_data1  = '0;
    bus.op_data2  = '0;
    bus.out_resp  = '0;
    bus.out_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) tick();
    check("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check("rst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
    check("rst_req_data", bus.req_data_out, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_err_stray", 32'(bus.err_stray), 32'd0);
    reset = 1'b0;
    tick();
    check("op_ready_after_rst", 32'(bus.op_ready), 32'd1);

    // ADD 5 + 7, result stalled 5 cycles while the next op is already offered.
    send_op(CmdAdd, 32'd5, 32'd7);
    sb_q.push_back('{code: 2'd1, data: 32'd12, tmo: 1'b0});
    respond(3, 2'd1, 32'd12);
    bus.op_valid = 1'b1;
    bus.op_cmd   = CmdAdd;
    bus.op_data1 = 32'hFFFF_FFFF;
    bus.op_data2 = 32'd1;
    collect(5);
    check("not_accepted_yet", 32'(bus.req_cmd_out), 32'd0);

    // ADD 0xFFFFFFFF + 1 overflows.
    send_op(CmdAdd, 32'hFFFF_FFFF, 32'd1);
    sb_q.push_back('{code: 2'd2, data: 32'd0, tmo: 1'b0});
    respond(2, 2'd2, 32'd0);
    collect(0);

    // Invalid command 3 passes through.
    send_op(4'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    sb_q.push_back('{code: 2'd3, data: 32'd0, tmo: 1'b0});
    respond(1, 2'd3, 32'd0);
    collect(0);

    // NOP completes immediately.
    sb_q.push_back('{code: 2'd0, data: 32'd0, tmo: 1'b0});
    send_op(CmdNop, 32'h55, 32'h66);
    collect(0);

    // Timeout: rsp_valid exactly at T+3+TIMEOUT; later response flags err_stray.
    send_op(CmdShl, 32'd3, 32'd2);
    sb_q.push_back('{code: 2'd0, data: 32'd0, tmo: 1'b1});
    repeat (Tmo) tick();
    check("tmo_early_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("tmo_valid", 32'(bus.rsp_valid), 32'd1);
    collect(0);
    check("stray_before", 32'(bus.err_stray), 32'd0);
    respond(5, 2'd1, 32'd99);
    tick();
    check("stray_after", 32'(bus.err_stray), 32'd1);
    check("stray_no_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset during WAIT_RESP aborts with no result.
    send_op(CmdShr, 32'd8, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("abort_op_ready", 32'(bus.op_ready), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_err_stray", 32'(bus.err_stray), 32'd0);
    check("abort_req_cmd", 32'(bus.req_cmd_out), 32'd0);
    reset = 1'b0;
    tick();
    check("abort_idle", 32'(bus.op_ready), 32'd1);
    repeat (Tmo + 3) tick();
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // SUB 9 - 4 after reset completes normally.
    send_op(CmdSub, 32'd9, 32'd4);
    sb_q.push_back('{code: 2'd1, data: 32'd5, tmo: 1'b0});
    respond(2, 2'd1, 32'd5);
    collect(0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
